// File: rtl/spi_master_tx.sv
// SPI mode-0 (CPOL=0, CPHA=0) master transmitter, MSB first, one word per cs-low frame.
// cs/sclk/mosi/done come straight from flops so the pins never glitch.
module spi_master_tx #(
  parameter int unsigned reg_width = 8,
  parameter int unsigned clk_div   = 4,
  parameter int unsigned cs_gap    = 2
) (
  input  logic                 sys_clk,
  input  logic                 rstn,
  input  logic [reg_width-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 cs,
  output logic                 sclk,
  output logic                 mosi
);
  localparam int unsigned   BW       = $clog2(reg_width) + 1;
  localparam logic [7:0]    DIV_LAST = 8'(clk_div - 1);
  localparam logic [7:0]    GAP_LAST = 8'(cs_gap - 1);
  localparam logic [BW-1:0] BITS     = BW'(reg_width);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP} state_e;

  state_e               state_q, state_d;
  logic [7:0]           div_cnt_q, div_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [reg_width-1:0] shift_q, shift_d;
  logic                 cs_q, cs_d, sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic                 phase_end;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    mosi_d    = 1'b0;
    phase_end = (state_q == GAP) ? (div_cnt_q == GAP_LAST) : (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          state_d   = SETUP;
          shift_d   = tx_data;
          bit_cnt_d = BITS;
        end
      end
      SETUP: if (phase_end) state_d = HIGH;
      HIGH: begin
        if (phase_end) begin
          bit_cnt_d = bit_cnt_q - BW'(1);
          if (bit_cnt_d == '0) begin
            state_d = HOLD;
          end else begin
            shift_d = {shift_q[reg_width-2:0], 1'b0};
            state_d = LOW;
          end
        end
      end
      LOW:     if (phase_end) state_d = HIGH;
      HOLD:    if (phase_end) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Each timed phase restarts its divider, so the counter never wraps.
    div_cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : div_cnt_q + 8'd1;

    // Pin values are computed for the state being entered and then registered.
    cs_d   = (state_d == IDLE) || (state_d == GAP);
    sclk_d = (state_d == HIGH);
    case (state_d)
      SETUP, LOW: mosi_d = shift_d[reg_width-1];
      HIGH, HOLD: mosi_d = mosi_q;
      default:    mosi_d = 1'b0;
    endcase
    done_d = (state_q == HOLD) && (state_d == GAP);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign cs       = cs_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: frame-level model compared every cycle against two instances
// (clk_div=4 and clk_div=1), plus a mode-0 receiver monitor and literal frame checks.
module tb_spi_master_tx;
  localparam int GAP_CYC = 2;

  typedef struct {
    logic [7:0] word;
    int         bits;
    int         low;
  } frame_t;

  logic       sys_clk;
  logic       rstn;
  logic [7:0] data0, data1;
  logic [1:0] valid_v;
  logic [1:0] ready_v, busy_v, done_v, cs_v, sclk_v, mosi_v;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_tx #(.reg_width(8), .clk_div(4), .cs_gap(GAP_CYC)) u_dut0 (
    .sys_clk(sys_clk), .rstn(rstn), .tx_data(data0), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .cs(cs_v[0]), .sclk(sclk_v[0]), .mosi(mosi_v[0])
  );

  spi_master_tx #(.reg_width(8), .clk_div(1), .cs_gap(GAP_CYC)) u_dut1 (
    .sys_clk(sys_clk), .rstn(rstn), .tx_data(data1), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .cs(cs_v[1]), .sclk(sclk_v[1]), .mosi(mosi_v[1])
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  // Expected {cs,sclk,mosi,done,tx_ready,busy} at position pos of a frame (-1 = idle).
  // The cs-low window is 2*8+1 phases of d cycles: odd phases have sclk high,
  // and phase p carries bit p/2 (MSB first), the last phase keeping the LSB.
  function automatic logic [5:0] expect_out(input int pos, input logic [7:0] w, input int d);
    int p;
    int idx;
    logic [5:0] e;
    e = 6'b100010;
    if (pos >= 0 && pos < 17 * d) begin
      p   = pos / d;
      idx = (p / 2 > 7) ? 7 : p / 2;
      e   = {1'b0, p[0], w[7 - idx], 1'b0, 1'b0, 1'b1};
    end else if (pos >= 17 * d) begin
      e = {1'b1, 1'b0, 1'b0, (pos == 17 * d), 1'b0, 1'b1};
    end
    return e;
  endfunction

  int         m_pos [2];
  logic [7:0] m_word[2];

  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 2; i++) m_pos[i] <= -1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (m_pos[i] < 0) begin
          if (valid_v[i]) begin
            m_pos[i]  <= 0;
            m_word[i] <= (i == 0) ? data0 : data1;
          end
        end else if (m_pos[i] == 17 * div_of(i) + GAP_CYC - 1) begin
          m_pos[i] <= -1;
        end else begin
          m_pos[i] <= m_pos[i] + 1;
        end
      end
    end
  end

  // Per-cycle compare plus a mode-0 receiver monitor, sampled on the falling edge.
  logic [7:0] rx_sh[2];
  int         rx_n[2], low_n[2], done_n[2];
  logic       prev_cs[2], prev_sclk[2];
  int         hi_run = 0, last_hi_run = 0;
  frame_t     fq0[$], fq1[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rx_sh[i] = '0; rx_n[i] = 0; low_n[i] = 0; done_n[i] = 0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0;
      m_pos[i] = -1; m_word[i] = '0;
    end
  end

  always @(negedge sys_clk) begin
    for (int i = 0; i < 2; i++) begin
      frame_t f;
      check($sformatf("cycle_dut%0d_pos%0d", i, m_pos[i]),
            {26'd0, cs_v[i], sclk_v[i], mosi_v[i], done_v[i], ready_v[i], busy_v[i]},
            {26'd0, expect_out(m_pos[i], m_word[i], div_of(i))});
      if (!cs_v[i] && sclk_v[i] && !prev_sclk[i]) begin
        rx_sh[i] = {rx_sh[i][6:0], mosi_v[i]};
        rx_n[i]++;
      end
      if (!cs_v[i]) low_n[i]++;
      if (done_v[i]) done_n[i]++;
      if (cs_v[i] && !prev_cs[i]) begin
        f.word = rx_sh[i]; f.bits = rx_n[i]; f.low = low_n[i];
        if (i == 0) fq0.push_back(f); else fq1.push_back(f);
        rx_n[i] = 0;
        low_n[i] = 0;
      end
      prev_cs[i]   = cs_v[i];
      prev_sclk[i] = sclk_v[i];
    end
    if (cs_v[0]) hi_run++;
    else if (hi_run > 0) begin
      last_hi_run = hi_run;
      hi_run = 0;
    end
  end

  task automatic send(input int i, input logic [7:0] w);
    @(negedge sys_clk);
    if (i == 0) begin valid_v[0] = 1'b1; data0 = w; end
    else        begin valid_v[1] = 1'b1; data1 = w; end
    @(negedge sys_clk);
    valid_v[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input string name);
    int n;
    n = 0;
    while (!ready_v[i] && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    if (!ready_v[i]) check({name, "_timeout"}, 32'(ready_v[i]), 32'd1);
  endtask

  task automatic check_frame(input string name, input frame_t f, input logic [7:0] w, input int low);
    check({name, "_word"}, 32'(f.word), 32'(w));
    check({name, "_bits"}, f.bits, 8);
    check({name, "_cs_low"}, f.low, low);
  endtask

  initial begin
    int b, d, n, rises;
    logic p;
    rstn = 1'b0; valid_v = 2'b00; data0 = '0; data1 = '0;

    // Reset held for 5 cycles, then released.
    repeat (5) @(negedge sys_clk);
    check("reset_pins", {26'd0, cs_v[0], sclk_v[0], mosi_v[0], done_v[0], ready_v[0], busy_v[0]},
          {26'd0, 6'b100010});
    rstn = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("after_reset_pins", {26'd0, cs_v[1], sclk_v[1], mosi_v[1], done_v[1], ready_v[1], busy_v[1]},
          {26'd0, 6'b100010});

    // Single frame 8'hA5 at clk_div=4: 68 cycles cs low, one done.
    b = fq0.size(); d = done_n[0];
    send(0, 8'hA5);
    wait_idle(0, "a5");
    check("a5_frames", fq0.size() - b, 1);
    if (fq0.size() > b) check_frame("a5", fq0[b], 8'hA5, 68);
    check("a5_done", done_n[0] - d, 1);

    // Back-to-back 8'hFF then 8'h00 with tx_valid held.
    b = fq0.size(); d = done_n[0];
    @(negedge sys_clk);
    valid_v[0] = 1'b1; data0 = 8'hFF;
    @(negedge sys_clk);
    data0 = 8'h00;
    n = 0;
    while (!ready_v[0] && n < 400) begin @(negedge sys_clk); n++; end
    @(negedge sys_clk);
    valid_v[0] = 1'b0;
    wait_idle(0, "b2b");
    check("b2b_frames", fq0.size() - b, 2);
    if (fq0.size() > b + 1) begin
      check_frame("b2b_ff", fq0[b], 8'hFF, 68);
      check_frame("b2b_00", fq0[b + 1], 8'h00, 68);
    end
    check("b2b_cs_high_gap", last_hi_run, 3);
    check("b2b_done", done_n[0] - d, 2);

    // tx_valid and tx_data wiggled during a 8'h3C frame must be ignored.
    b = fq0.size(); d = done_n[0];
    send(0, 8'h3C);
    repeat (10) @(negedge sys_clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      valid_v[0] = 1'b1;
      data0 = k[0] ? 8'hC3 : 8'h5A;
    end
    check("busy_ready_low", 32'(ready_v[0]), 32'd0);
    @(negedge sys_clk);
    valid_v[0] = 1'b0;
    wait_idle(0, "busy");
    repeat (10) @(negedge sys_clk);
    check("busy_frames", fq0.size() - b, 1);
    if (fq0.size() > b) check_frame("busy", fq0[b], 8'h3C, 68);
    check("busy_done", done_n[0] - d, 1);

    // Reset after the 3rd sclk rising edge of 8'hF0.
    b = fq0.size(); d = done_n[0];
    send(0, 8'hF0);
    rises = 0; p = sclk_v[0]; n = 0;
    while (rises < 3 && n < 400) begin
      @(negedge sys_clk);
      if (sclk_v[0] && !p) rises++;
      p = sclk_v[0];
      n++;
    end
    check("rst_three_rises", rises, 3);
    @(posedge sys_clk);
    #1 rstn = 1'b0;
    #1 check("rst_async_cs_sclk", {30'd0, cs_v[0], sclk_v[0]}, {30'd0, 2'b10});
    repeat (3) @(negedge sys_clk);
    rstn = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_no_done", done_n[0] - d, 0);
    check("rst_partial_frames", fq0.size() - b, 1);
    if (fq0.size() > b) check("rst_partial_bits", fq0[b].bits, 3);
    b = fq0.size(); d = done_n[0];
    send(0, 8'h81);
    wait_idle(0, "post_rst");
    check("post_rst_frames", fq0.size() - b, 1);
    if (fq0.size() > b) check_frame("post_rst", fq0[b], 8'h81, 68);
    check("post_rst_done", done_n[0] - d, 1);

    // Minimum divider: 8'h5A at clk_div=1, 17 cycles cs low.
    b = fq1.size(); d = done_n[1];
    send(1, 8'h5A);
    wait_idle(1, "div1");
    check("div1_frames", fq1.size() - b, 1);
    if (fq1.size() > b) check_frame("div1", fq1[b], 8'h5A, 17);
    check("div1_done", done_n[1] - d, 1);

    repeat (5) @(negedge sys_clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master transmitter, mode 0 (CPOL=0, CPHA=0), MSB first. It is the initiator end of the cs/sclk/mosi link that the LED board's SPI receiver consumes.
- Accepts a parallel word over a valid/ready handshake and generates cs, sclk and mosi from sys_clk.
- Sits between the on-chip stimulus source (test pattern / command logic) and the SPI pins.
- Exactly one word is sent per cs-low frame.

Parameters:
- reg_width, 8: bits per frame; shift register width.
- clk_div, 4: sys_clk cycles per sclk half-period; legal range 1..255.
- cs_gap, 2: minimum sys_clk cycles cs stays high after a frame; legal range 1..255.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rstn  input  1  asynchronous active-low reset.
- tx_data  input  reg_width  word to transmit; sampled only on handshake.
- tx_valid  input  1  word available.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a frame completes.
- cs  output  1  chip select, active low.
- sclk  output  1  SPI clock; idles low.
- mosi  output  1  serial data, MSB first.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset rstn is asynchronous and active-low.
- Registered outputs: cs, sclk, mosi and done come directly from flops.
- Reset values (immediate on rstn=0, regardless of state): state=IDLE, cs=1, sclk=0, mosi=0, done=0, busy=0, tx_ready=1, shift register=0, counters=0.
- Internal counters:
  - div_cnt counts 0..clk_div-1 within each timed state.
  - bit_cnt is $clog2(reg_width)+1 bits wide and loads reg_width at accept.
- Handshake:
  - Accept occurs on a cycle with tx_valid=1 and tx_ready=1.
  - On accept, the shift register loads tx_data and the state moves to SETUP.
  - tx_valid while busy is ignored.
  - tx_data changes after accept have no effect on the frame.
- State machine; each timed state lasts exactly clk_div cycles:
  - IDLE: cs=1, sclk=0, mosi=0. On accept -> SETUP.
  - SETUP: cs=0, sclk=0, mosi=shift[MSB]. -> HIGH.
  - HIGH: sclk=1, mosi held. At exit, bit_cnt decrements. If the new bit_cnt is 0 -> HOLD; otherwise shift left by 1 -> LOW.
  - LOW: sclk=0, mosi=shift[MSB], updated on entry (the falling edge). -> HIGH.
  - HOLD: cs=0, sclk=0, mosi held. -> GAP.
  - GAP: cs=1, sclk=0, mosi=0, lasts cs_gap cycles. done=1 on the first GAP cycle only. -> IDLE.
- Timing:
  - cs goes low the cycle after accept.
  - Exactly reg_width sclk rising edges per frame.
  - mosi is stable for clk_div cycles before every rising edge and for clk_div cycles after it.
  - cs-low duration = (2*reg_width+1)*clk_div cycles.
- Back-to-back frames: with tx_valid held high, cs is high for cs_gap+1 cycles between frames (GAP plus one IDLE accept cycle).
- Arithmetic: counters wrap never. div_cnt resets to 0 on every state change. bit_cnt never underflows, because HOLD is entered at 0.
- Reset mid-frame: cs rises and sclk falls asynchronously. done is not pulsed. The partial word is discarded, with no resume after rstn releases.
- clk_div=1: sclk period is 2 sys_clk cycles, and the first rising edge is 1 cycle after cs falls.

Test Plan:
- Reset: hold rstn=0 for 5 cycles, then release -> cs=1, sclk=0, mosi=0, tx_ready=1, busy=0, done=0 throughout and after.
- Single frame: clk_div=4, send 8'hA5 -> cs low for 68 cycles; 8 sclk rising edges; mosi sampled at rising edges = 1,0,1,0,0,1,0,1; one done pulse on the cycle cs rises; a mode-0 receiver model captures 8'hA5.
- Back-to-back: tx_valid held with 8'hFF then 8'h00, cs_gap=2 -> two frames, cs high exactly 3 cycles between them; mosi all 1 then all 0; two done pulses.
- Busy ignore: during a frame of 8'h3C, pulse tx_valid with 8'hC3 and toggle tx_data -> tx_ready=0 during the frame; transmitted bits = 8'h3C; no extra frame.
- Reset mid-frame: assert rstn=0 after the 3rd sclk rising edge of 8'hF0 -> cs=1, sclk=0 in the same cycle (asynchronous); no done pulse. A following 8'h81 frame is sent complete and correct.
- Minimum divider: clk_div=1, send 8'h5A -> sclk period 2 cycles; cs low 17 cycles; bits 0,1,0,1,1,0,1,0.
